// File: rtl/multdiv_iter_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_iter_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude of a two's complement value; INT_MIN maps to 2^(WIDTH-1) as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter: counts steps while enabled, cleared on each new start.
module iter_counter
    import multdiv_iter_pkg::*;
(
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             wrap_c
);

    // Up counter with synchronous clear taking priority over increment.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Last step of a pass: the counter is about to wrap back to zero.
    assign wrap_c = (count == '1);

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, one step per cycle.
module multdiv_iter
    import multdiv_iter_pkg::*;
(
    input  logic             clk,
    input  logic             res,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t             state;
    state_t             state_next;
    logic               start_mult;
    logic               start_div;
    logic               start;
    logic               step_en;
    logic               wrap_c;
    logic [CNT_W-1:0]   count;

    // Booth datapath
    logic [2*WIDTH:0]   prod;
    logic [2*WIDTH:0]   prod_next;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     hi_ext;
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     mul_upper;
    logic               mul_ovf;

    // Restoring divide datapath
    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo;
    logic [CNT_W-1:0]   bit_idx;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     dvs_ext;
    logic               ge;
    logic               is_div;
    logic               neg;
    logic               div_zero;
    logic               div_ovf;

    logic [WIDTH-1:0]   fin_result;
    logic               fin_exc;

    assign start = start_mult | start_div;

    iter_counter u_iter_counter (
        .clk    (clk),
        .res    (res),
        .en     (step_en),
        .clr    (start),
        .count  (count),
        .wrap_c (wrap_c)
    );

    // State register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a start strobe overrides whatever is in flight, multiply wins a tie.
    always_comb begin
        state_next = state;
        start_mult = ctrl_MULT;
        start_div  = ctrl_DIV & ~ctrl_MULT;
        step_en    = 1'b0;
        case (state)
            IDLE: state_next = IDLE;
            MULT, DIV: begin
                step_en = 1'b1;
                if (wrap_c) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (start_mult) begin
            state_next = MULT;
        end else if (start_div) begin
            state_next = DIV;
        end
    end

    // One Booth step: add/sub multiplicand into the sign-extended upper half, then shift.
    always_comb begin
        hi_ext = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
        a_ext  = {mcand[WIDTH-1], mcand};
        case (prod[1:0])
            2'b01:   booth_sum = hi_ext + a_ext;
            2'b10:   booth_sum = hi_ext - a_ext;
            default: booth_sum = hi_ext;
        endcase
        prod_next = {booth_sum, prod[WIDTH:1]};
    end

    // One restoring step: bring down the next dividend bit MSB-first, subtract if it fits.
    always_comb begin
        bit_idx  = CNT_W'(WIDTH - 1) - count;
        shifted  = {rem, dvd_mag[bit_idx]};
        dvs_ext  = {1'b0, dvs_mag};
        ge       = (shifted >= dvs_ext);
        rem_next = ge ? WIDTH'(shifted - dvs_ext) : WIDTH'(shifted);
    end

    // Final result selection and exception flags.
    always_comb begin
        mul_upper = prod[2*WIDTH:WIDTH];
        mul_ovf   = ~((&mul_upper) | ~(|mul_upper));
        if (is_div) begin
            if (div_zero) begin
                fin_result = '0;
            end else begin
                fin_result = neg ? (~quo + WIDTH'(1)) : quo;
            end
            fin_exc = div_zero | div_ovf;
        end else begin
            fin_result = prod[WIDTH:1];
            fin_exc    = mul_ovf;
        end
    end

    // Operand capture on start, then one iteration per cycle in the active state.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            prod     <= '0;
            mcand    <= '0;
            dvd_mag  <= '0;
            dvs_mag  <= '0;
            rem      <= '0;
            quo      <= '0;
            is_div   <= 1'b0;
            neg      <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (start) begin
            prod     <= {WIDTH'(0), data_operandB, 1'b0};
            mcand    <= data_operandA;
            dvd_mag  <= abs_val(data_operandA);
            dvs_mag  <= abs_val(data_operandB);
            rem      <= '0;
            quo      <= '0;
            is_div   <= start_div;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
        end else if (state == MULT) begin
            prod <= prod_next;
        end else if (state == DIV) begin
            rem <= rem_next;
            quo <= {quo[WIDTH-2:0], ge};
        end
    end

    // Registered outputs: result/flag load and RDY strobe in DONE, busy from start to RDY.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (state == DONE) begin
                data_result    <= fin_result;
                data_exception <= fin_exc;
                data_resultRDY <= 1'b1;
            end
            if (start) begin
                busy <= 1'b1;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
